// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the fifo-fed UART transmitter:
// FSM state encoding and the idle level of the serial line.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    localparam logic TXD_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high.
// Ports: clk, rst (async, high), clr, run -> tick (on wrap), count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          run,
    output logic          tick,
    output logic [TW-1:0] count
);

    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    assign tick = run && (count == LAST);

    // Held at zero whenever not running so each frame starts aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr || !run || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Fifo read-side consumer that serialises each popped byte onto txd.
// Ports: clk, rst, clr, en, empty, fifo_dout -> rd, txd, busy, done.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              rd,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [TW-1:0] PRE   = TW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] DLAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] SLAST = CW'(STOP_BITS - 1);

    state_t            state;
    state_t            nxt;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_d;
    logic [CW-1:0]     bcnt;
    logic [CW-1:0]     bcnt_d;
    logic              rd_d;
    logic              txd_d;
    logic              busy_d;
    logic              done_d;
    logic              go;
    logic              run;
    logic              tick;
    logic [TW-1:0]     tcnt;

    assign go  = en && !empty;
    assign run = (state == ST_START) ||
                 (state == ST_DATA)  ||
                 (state == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .run  (run),
        .tick (tick),
        .count(tcnt)
    );

    always_comb begin
        nxt    = state;
        sh_d   = sh;
        bcnt_d = bcnt;
        case (state)
            ST_IDLE: begin
                if (go)
                    nxt = ST_POP;
            end
            ST_POP: begin
                nxt = ST_LOAD;
            end
            ST_LOAD: begin
                nxt    = ST_START;
                sh_d   = fifo_dout;
                bcnt_d = '0;
            end
            ST_START: begin
                if (tick)
                    nxt = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    sh_d = sh >> 1;
                    if (bcnt == DLAST) begin
                        nxt    = ST_STOP;
                        bcnt_d = '0;
                    end else begin
                        bcnt_d = bcnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bcnt == SLAST) begin
                        nxt    = go ? ST_POP : ST_IDLE;
                        bcnt_d = '0;
                    end else begin
                        bcnt_d = bcnt + 1'b1;
                    end
                end
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase

        if (clr) begin
            nxt    = ST_IDLE;
            bcnt_d = '0;
        end

        // Outputs are registered, so they are decoded from the next state.
        rd_d   = (nxt == ST_POP);
        busy_d = (nxt != ST_IDLE);
        txd_d  = TXD_IDLE;
        if (nxt == ST_START)
            txd_d = 1'b0;
        else if (nxt == ST_DATA)
            txd_d = sh_d[0];

        // One cycle before the final stop cycle, so done lands on it.
        done_d = !clr && (state == ST_STOP) &&
                 (tcnt == PRE) && (bcnt == SLAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sh    <= '0;
            bcnt  <= '0;
            rd    <= 1'b0;
            txd   <= TXD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            sh    <= sh_d;
            bcnt  <= bcnt_d;
            rd    <= rd_d;
            txd   <= txd_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with behavioural fifo models.
// Instance 1: one stop bit; instance 2: two stop bits.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       clr1  = 1'b0;
    logic       en1   = 1'b0;
    logic       fake1 = 1'b0;
    logic       empty1;
    logic [7:0] dout1 = '0;
    logic       rd1, txd1, busy1, done1;

    logic       clr2 = 1'b0;
    logic       en2  = 1'b0;
    logic       empty2;
    logic [7:0] dout2 = '0;
    logic       rd2, txd2, busy2, done2;

    logic [7:0] mem1 [0:63];
    logic [7:0] mem2 [0:63];
    int wp1 = 0;
    int rp1 = 0;
    int wp2 = 0;
    int rp2 = 0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign empty1 = (wp1 == rp1) && !fake1;
    assign empty2 = (wp2 == rp2);

    always @(posedge clk) begin
        if (rd1 && (wp1 != rp1)) begin
            dout1 <= mem1[rp1 % 64];
            rp1   <= rp1 + 1;
        end
    end

    always @(posedge clk) begin
        if (rd2 && (wp2 != rp2)) begin
            dout2 <= mem2[rp2 % 64];
            rp2   <= rp2 + 1;
        end
    end

    fifo_uart_tx #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr1), .en(en1),
        .empty(empty1), .fifo_dout(dout1),
        .rd(rd1), .txd(txd1), .busy(busy1), .done(done1)
    );

    fifo_uart_tx #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .rst(rst), .clr(clr2), .en(en2),
        .empty(empty2), .fifo_dout(dout2),
        .rd(rd2), .txd(txd2), .busy(busy2), .done(done2)
    );

    function automatic logic [3:0] outs(input int s);
        if (s == 0)
            return {rd1, txd1, busy1, done1};
        return {rd2, txd2, busy2, done2};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] o,
                       input logic [31:0] e);
        n_chk++;
        assert (o === e)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Advance to the next negedge and check the rd/empty rule there.
    task automatic step();
        @(negedge clk);
        if (!rst)
            chk("rd_while_empty",
                {31'b0, (rd1 && empty1) || (rd2 && empty2)}, 0);
    endtask

    task automatic push(input int s, input logic [7:0] b);
        if (s == 0) begin
            mem1[wp1 % 64] = b;
            wp1++;
        end else begin
            mem2[wp2 % 64] = b;
            wp2++;
        end
    endtask

    task automatic wait_rd(input int s);
        logic [3:0] o;
        int k;
        k = 0;
        o = outs(s);
        while (!o[3] && k < 300) begin
            step();
            o = outs(s);
            k++;
        end
        chk("rd_seen", {31'b0, o[3]}, 1);
    endtask

    // Entered anywhere before the pop; leaves on the cycle after done.
    task automatic frame(input int s, input logic [7:0] b,
                         output int rdc);
        logic [3:0] o;
        int nst;
        int tot;
        int idx;
        logic t;
        nst = (s == 0) ? 1 : 2;
        tot = (9 + nst) * CPB;
        wait_rd(s);
        rdc = cyc;
        step();
        chk("load", {28'b0, outs(s)}, 4'b0110);
        step();
        for (int c = 1; c <= tot; c++) begin
            idx = (c - 1) / CPB;
            if (idx == 0)
                t = 1'b0;
            else if (idx <= 8)
                t = b[idx-1];
            else
                t = 1'b1;
            chk("frame", {28'b0, outs(s)},
                {28'b0, 1'b0, t, 1'b1, c == tot});
            step();
        end
        o = outs(s);
        chk("done_one_cycle", {31'b0, o[0]}, 0);
    endtask

    int r;
    int rb [0:3];

    initial begin
        // 1: reset held with data apparently present, en low
        fake1 = 1'b1;
        rst   = 1'b1;
        repeat (10) begin
            step();
            chk("reset_dut1", {28'b0, outs(0)}, 4'b0100);
            chk("reset_dut2", {28'b0, outs(1)}, 4'b0100);
        end
        rst = 1'b0;
        repeat (10) begin
            step();
            chk("post_reset", {28'b0, outs(0)}, 4'b0100);
        end
        fake1 = 1'b0;

        // 2: single byte
        push(0, 8'hA5);
        en1 = 1'b1;
        frame(0, 8'hA5, r);
        repeat (5) begin
            chk("single_idle", {28'b0, outs(0)}, 4'b0100);
            step();
        end

        // 3: burst of four, back-to-back
        for (int i = 0; i < 4; i++)
            push(0, 8'(i));
        for (int i = 0; i < 4; i++) begin
            frame(0, 8'(i), rb[i]);
            if (i > 0)
                chk("burst_period", rb[i] - rb[i-1], 42);
        end
        chk("burst_empty", {31'b0, empty1}, 1);
        chk("burst_idle", {28'b0, outs(0)}, 4'b0100);

        // 4: enabled with nothing to send
        repeat (100) begin
            step();
            chk("empty_idle", {28'b0, outs(0)}, 4'b0100);
        end

        // 5: clr in the middle of data bit 3 of 0x3C
        push(0, 8'h3C);
        wait_rd(0);
        step();
        step();
        repeat (17) step();
        chk("pre_clr", {28'b0, outs(0)}, 4'b0110);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        chk("clr_next", {28'b0, outs(0)}, 4'b0100);
        repeat (20) begin
            step();
            chk("clr_quiet", {28'b0, outs(0)}, 4'b0100);
        end
        push(0, 8'h55);
        frame(0, 8'h55, r);
        chk("after_clr_idle", {28'b0, outs(0)}, 4'b0100);

        // 6: async reset between edges during START
        push(0, 8'h81);
        wait_rd(0);
        step();
        step();
        chk("in_start", {28'b0, outs(0)}, 4'b0010);
        #1 rst = 1'b1;
        #1 chk("async_rst", {28'b0, outs(0)}, 4'b0100);
        step();
        rst = 1'b0;
        repeat (10) begin
            step();
            chk("rst_idle", {28'b0, outs(0)}, 4'b0100);
        end

        // 7: two stop bits
        en2 = 1'b1;
        push(1, 8'hA5);
        frame(1, 8'hA5, r);
        chk("stop2_idle", {28'b0, outs(1)}, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
